// File: rtl/hci_bank_arbiter.sv
// Per-bank N_IN:1 arbiter between HCI branches and memory banks.
// Fixed priority with starvation escape or round-robin; responses return one cycle after handshake.
module hci_bank_arbiter #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_MEM = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned BW    = DW / 8,
  parameter int unsigned IW    = 8,
  parameter int unsigned SW    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      mode_i,
  input  logic [SW-1:0]             max_stall_i,
  input  logic [N_IN*N_MEM-1:0]     in_req_i,
  output logic [N_IN*N_MEM-1:0]     in_gnt_o,
  input  logic [N_IN*N_MEM*AW-1:0]  in_add_i,
  input  logic [N_IN*N_MEM-1:0]     in_wen_i,
  input  logic [N_IN*N_MEM*BW-1:0]  in_be_i,
  input  logic [N_IN*N_MEM*DW-1:0]  in_data_i,
  input  logic [N_IN*N_MEM*IW-1:0]  in_id_i,
  output logic [N_IN*N_MEM-1:0]     in_r_valid_o,
  output logic [N_IN*N_MEM*DW-1:0]  in_r_data_o,
  output logic [N_IN*N_MEM*IW-1:0]  in_r_id_o,
  output logic [N_MEM-1:0]          mem_req_o,
  input  logic [N_MEM-1:0]          mem_gnt_i,
  output logic [N_MEM*AW-1:0]       mem_add_o,
  output logic [N_MEM-1:0]          mem_wen_o,
  output logic [N_MEM*BW-1:0]       mem_be_o,
  output logic [N_MEM*DW-1:0]       mem_data_o,
  input  logic [N_MEM*DW-1:0]       mem_r_data_i
);

  localparam int unsigned PtrW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [SW-1:0]   cnt_q  [N_IN][N_MEM];
  logic [SW-1:0]   cnt_d  [N_IN][N_MEM];
  logic [PtrW-1:0] ptr_q  [N_MEM];
  logic [PtrW-1:0] ptr_d  [N_MEM];
  logic [PtrW-1:0] rsel_q [N_MEM];
  logic [PtrW-1:0] rsel_d [N_MEM];
  logic [IW-1:0]   rid_q  [N_MEM];
  logic [IW-1:0]   rid_d  [N_MEM];
  logic [N_MEM-1:0] rpend_q, rpend_d;

  logic [PtrW-1:0] low_w [N_MEM];
  logic [PtrW-1:0] esc_w [N_MEM];
  logic [PtrW-1:0] rr_w  [N_MEM];
  logic [PtrW-1:0] win   [N_MEM];
  logic [IW-1:0]   sel_id [N_MEM];
  logic [N_MEM-1:0] esc_v, req_any, hs;

  // Winner selection; descending loops let the lowest index (or offset) win.
  always_comb begin : p_win
    int idx;
    idx = 0;
    for (int m = 0; m < int'(N_MEM); m++) begin
      low_w[m]   = '0;
      esc_w[m]   = '0;
      rr_w[m]    = '0;
      esc_v[m]   = 1'b0;
      req_any[m] = 1'b0;
      for (int b = int'(N_IN) - 1; b >= 0; b--) begin
        if (in_req_i[b*int'(N_MEM)+m]) begin
          req_any[m] = 1'b1;
          low_w[m]   = PtrW'(b);
          if ((max_stall_i != '0) && (cnt_q[b][m] >= max_stall_i)) begin
            esc_v[m] = 1'b1;
            esc_w[m] = PtrW'(b);
          end
        end
      end
      for (int i = int'(N_IN) - 1; i >= 0; i--) begin
        idx = int'(ptr_q[m]) + i;
        if (idx >= int'(N_IN)) idx = idx - int'(N_IN);
        if (in_req_i[idx*int'(N_MEM)+m]) rr_w[m] = PtrW'(idx);
      end
      if (mode_i)        win[m] = rr_w[m];
      else if (esc_v[m]) win[m] = esc_w[m];
      else               win[m] = low_w[m];
    end
  end

  assign mem_req_o = req_any;
  assign hs        = req_any & mem_gnt_i;

  always_comb begin : p_mux
    in_gnt_o   = '0;
    mem_add_o  = '0;
    mem_wen_o  = '0;
    mem_be_o   = '0;
    mem_data_o = '0;
    for (int m = 0; m < int'(N_MEM); m++) begin
      sel_id[m] = '0;
      for (int b = 0; b < int'(N_IN); b++) begin
        if (win[m] == PtrW'(b)) begin
          in_gnt_o[b*int'(N_MEM)+m]  = hs[m];
          mem_add_o[m*AW +: AW]      = in_add_i[(b*int'(N_MEM)+m)*AW +: AW];
          mem_wen_o[m]               = in_wen_i[b*int'(N_MEM)+m];
          mem_be_o[m*BW +: BW]       = in_be_i[(b*int'(N_MEM)+m)*BW +: BW];
          mem_data_o[m*DW +: DW]     = in_data_i[(b*int'(N_MEM)+m)*DW +: DW];
          sel_id[m]                  = in_id_i[(b*int'(N_MEM)+m)*IW +: IW];
        end
      end
    end
  end

  // Responses are masked during reset/clear so a pending one is dropped immediately.
  always_comb begin : p_rsp
    in_r_valid_o = '0;
    in_r_data_o  = '0;
    in_r_id_o    = '0;
    for (int b = 0; b < int'(N_IN); b++) begin
      for (int m = 0; m < int'(N_MEM); m++) begin
        in_r_valid_o[b*int'(N_MEM)+m] = rst_ni & ~clear_i & rpend_q[m] &
                                        (rsel_q[m] == PtrW'(b));
        in_r_data_o[(b*int'(N_MEM)+m)*DW +: DW] = mem_r_data_i[m*DW +: DW];
        in_r_id_o[(b*int'(N_MEM)+m)*IW +: IW]   = rid_q[m];
      end
    end
  end

  always_comb begin : p_next
    for (int m = 0; m < int'(N_MEM); m++) begin
      for (int b = 0; b < int'(N_IN); b++) begin
        if (!in_req_i[b*int'(N_MEM)+m] || in_gnt_o[b*int'(N_MEM)+m]) begin
          cnt_d[b][m] = '0;
        end else if (cnt_q[b][m] != '1) begin
          cnt_d[b][m] = cnt_q[b][m] + 1'b1;
        end else begin
          cnt_d[b][m] = cnt_q[b][m];
        end
      end
      ptr_d[m]   = ptr_q[m];
      rsel_d[m]  = rsel_q[m];
      rid_d[m]   = rid_q[m];
      rpend_d[m] = hs[m];
      if (hs[m]) begin
        ptr_d[m]  = (win[m] == PtrW'(N_IN - 1)) ? '0 : win[m] + 1'b1;
        rsel_d[m] = win[m];
        rid_d[m]  = sel_id[m];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int m = 0; m < int'(N_MEM); m++) begin
        for (int b = 0; b < int'(N_IN); b++) cnt_q[b][m] <= '0;
        ptr_q[m]  <= '0;
        rsel_q[m] <= '0;
        rid_q[m]  <= '0;
      end
      rpend_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rsel_q  <= rsel_d;
      rid_q   <= rid_d;
      rpend_q <= rpend_d;
    end
  end

endmodule

// File: tb/tb_hci_bank_arbiter.sv
// Directed bench for hci_bank_arbiter: a combinational vector table plus multi-cycle sequences.
module tb_hci_bank_arbiter;

  localparam int N_IN = 3, N_MEM = 4, AW = 32, DW = 32, BW = 4, IW = 8, SW = 8;

  logic                     clk_i = 1'b0;
  logic                     rst_ni, clear_i, mode_i;
  logic [SW-1:0]            max_stall_i;
  logic [N_IN*N_MEM-1:0]    in_req_i, in_gnt_o, in_wen_i, in_r_valid_o;
  logic [N_IN*N_MEM*AW-1:0] in_add_i;
  logic [N_IN*N_MEM*BW-1:0] in_be_i;
  logic [N_IN*N_MEM*DW-1:0] in_data_i, in_r_data_o;
  logic [N_IN*N_MEM*IW-1:0] in_id_i, in_r_id_o;
  logic [N_MEM-1:0]         mem_req_o, mem_gnt_i, mem_wen_o;
  logic [N_MEM*AW-1:0]      mem_add_o;
  logic [N_MEM*BW-1:0]      mem_be_o;
  logic [N_MEM*DW-1:0]      mem_data_o, mem_r_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  hci_bank_arbiter #(
    .N_IN(N_IN), .N_MEM(N_MEM), .AW(AW), .DW(DW), .BW(BW), .IW(IW), .SW(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .mode_i(mode_i),
    .max_stall_i(max_stall_i), .in_req_i(in_req_i), .in_gnt_o(in_gnt_o),
    .in_add_i(in_add_i), .in_wen_i(in_wen_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
    .in_id_i(in_id_i), .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
    .in_r_id_o(in_r_id_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o),
    .mem_data_o(mem_data_o), .mem_r_data_i(mem_r_data_i)
  );

  typedef struct {
    logic        mode;
    logic [7:0]  ms;
    logic [11:0] req;
    logic [3:0]  mg;
    logic [11:0] gnt;
    logic [3:0]  mreq;
    logic [7:0]  win;   // 2 bits per bank: expected winning branch
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; return 1ns after the falling edge.
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    in_req_i  = '0;
    mem_gnt_i = '1;
    clear_i   = 1'b1;
    cyc();
    clear_i   = 1'b0;
  endtask

  initial begin
    logic [11:0] prev;
    logic [11:0] exp;
    int          k;
    int          b;

    vecs[0] = '{1'b0, 8'd0, 12'h000, 4'hF, 12'h000, 4'b0000, 8'h00};
    vecs[1] = '{1'b0, 8'd0, 12'h040, 4'hF, 12'h040, 4'b0100, 8'h10};
    vecs[2] = '{1'b0, 8'd0, 12'h911, 4'hF, 12'h801, 4'b1001, 8'h80};
    vecs[3] = '{1'b0, 8'd0, 12'h911, 4'h1, 12'h001, 4'b1001, 8'h80};
    vecs[4] = '{1'b0, 8'd0, 12'hFFF, 4'hF, 12'h00F, 4'b1111, 8'h00};
    vecs[5] = '{1'b0, 8'd0, 12'hFF0, 4'hA, 12'h0A0, 4'b1111, 8'h55};
    vecs[6] = '{1'b1, 8'd0, 12'hF00, 4'hF, 12'hF00, 4'b1111, 8'hAA};
    vecs[7] = '{1'b0, 8'd5, 12'h505, 4'hF, 12'h005, 4'b0101, 8'h00};

    rst_ni = 1'b0; clear_i = 1'b0; mode_i = 1'b0; max_stall_i = '0;
    mem_gnt_i = '1; mem_r_data_i = '0;
    for (int i = 0; i < N_IN * N_MEM; i++) begin
      in_add_i[i*AW +: AW]  = 32'h1000 + 32'(i);
      in_data_i[i*DW +: DW] = 32'hA000_0000 + 32'(i);
      in_be_i[i*BW +: BW]   = 4'(i);
      in_wen_i[i]           = (i % 2) == 1;
      in_id_i[i*IW +: IW]   = 8'h40 + 8'(i);
    end
    in_req_i = 12'h040;

    // Reset: grant path stays combinational, no responses.
    @(negedge clk_i); #1;
    check("rst_mem_req", 64'(mem_req_o), 64'h4);
    check("rst_gnt", 64'(in_gnt_o), 64'h040);
    check("rst_rvalid", 64'(in_r_valid_o), 64'h0);
    cyc();
    rst_ni = 1'b1; in_req_i = '0; #1;
    check("post_rst_rvalid", 64'(in_r_valid_o), 64'h0);

    for (int v = 0; v < 8; v++) begin
      do_clear();
      mode_i = vecs[v].mode; max_stall_i = vecs[v].ms;
      in_req_i = vecs[v].req; mem_gnt_i = vecs[v].mg; #1;
      check($sformatf("vec%0d_gnt", v), 64'(in_gnt_o), 64'(vecs[v].gnt));
      check($sformatf("vec%0d_mem_req", v), 64'(mem_req_o), 64'(vecs[v].mreq));
      for (int m = 0; m < N_MEM; m++) begin
        if (vecs[v].mreq[m]) begin
          b = int'(vecs[v].win[2*m +: 2]);
          k = b * N_MEM + m;
          check($sformatf("vec%0d_add%0d", v, m), 64'(mem_add_o[m*AW +: AW]),
                64'(32'h1000 + 32'(k)));
          check($sformatf("vec%0d_data%0d", v, m), 64'(mem_data_o[m*DW +: DW]),
                64'(32'hA000_0000 + 32'(k)));
          check($sformatf("vec%0d_be%0d", v, m), 64'(mem_be_o[m*BW +: BW]), 64'(k % 16));
          check($sformatf("vec%0d_wen%0d", v, m), 64'(mem_wen_o[m]), 64'(k % 2));
        end
      end
    end

    // Fixed priority, threshold 3: b0,b0,b0,b2 repeating; responses track grants.
    do_clear();
    mode_i = 1'b0; max_stall_i = 8'd3; in_req_i = 12'h202; #1;
    prev = '0;
    for (int c = 0; c < 8; c++) begin
      exp = (c % 4 == 3) ? 12'h200 : 12'h002;
      check($sformatf("starve_gnt%0d", c), 64'(in_gnt_o), 64'(exp));
      check($sformatf("starve_rv%0d", c), 64'(in_r_valid_o), 64'(prev));
      prev = exp;
      cyc();
    end
    check("starve_rv_last", 64'(in_r_valid_o), 64'(prev));

    // Round-robin over three branches on bank 0, pointer wraps.
    do_clear();
    mode_i = 1'b1; max_stall_i = '0; in_req_i = 12'h111; #1;
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      exp = 12'h001 << (4 * (c % 3));
      check($sformatf("rr_gnt%0d", c), 64'(in_gnt_o), 64'(exp));
      check($sformatf("rr_rv%0d", c), 64'(in_r_valid_o), 64'(prev));
      prev = exp;
      cyc();
    end

    // Read response routing from bank 2 to branch 1.
    do_clear();
    mode_i = 1'b0;
    in_add_i[6*AW +: AW] = 32'h10; in_id_i[6*IW +: IW] = 8'd5; in_wen_i[6] = 1'b1;
    in_req_i = 12'h040; #1;
    check("rd_gnt", 64'(in_gnt_o), 64'h040);
    check("rd_mem_add", 64'(mem_add_o[2*AW +: AW]), 64'h10);
    check("rd_mem_wen", 64'(mem_wen_o[2]), 64'h1);
    cyc();
    in_req_i = '0;
    mem_r_data_i = {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333}; #1;
    check("rd_rvalid", 64'(in_r_valid_o), 64'h040);
    check("rd_rdata", 64'(in_r_data_o[6*DW +: DW]), 64'hDEAD_BEEF);
    check("rd_rid", 64'(in_r_id_o[6*IW +: IW]), 64'h5);
    cyc();
    check("rd_rvalid_once", 64'(in_r_valid_o), 64'h0);

    // Round-robin stall on bank 3: pointer holds, counters climb.
    do_clear();
    mode_i = 1'b1; in_req_i = 12'h008; #1;
    check("stall_pre_gnt", 64'(in_gnt_o), 64'h008);
    cyc();
    in_req_i = 12'h808; mem_gnt_i = 4'b0111; #1;
    check("stall_gnt0", 64'(in_gnt_o), 64'h0);
    check("stall_rv0", 64'(in_r_valid_o), 64'h008);
    cyc();
    check("stall_gnt1", 64'(in_gnt_o), 64'h0);
    check("stall_rv1", 64'(in_r_valid_o), 64'h0);
    cyc();
    check("stall_rv2", 64'(in_r_valid_o), 64'h0);
    check("stall_cnt0", 64'(dut.cnt_q[0][3]), 64'd2);
    check("stall_cnt2", 64'(dut.cnt_q[2][3]), 64'd2);
    check("stall_ptr", 64'(dut.ptr_q[3]), 64'd1);
    mem_gnt_i = 4'hF; #1;
    check("stall_release_gnt", 64'(in_gnt_o), 64'h800);
    cyc();
    in_req_i = '0; #1;
    check("stall_release_rv", 64'(in_r_valid_o), 64'h800);

    // Reset right after a handshake drops the response and clears state.
    do_clear();
    mode_i = 1'b1; in_req_i = 12'h010; #1;
    cyc();
    rst_ni = 1'b0; in_req_i = 12'h110; #1;
    check("rst_drop_rv", 64'(in_r_valid_o), 64'h0);
    cyc();
    rst_ni = 1'b1; in_req_i = '0; #1;
    check("rst_drop_rv1", 64'(in_r_valid_o), 64'h0);
    check("rst_drop_ptr", 64'(dut.ptr_q[0]), 64'd0);
    check("rst_drop_cnt", 64'(dut.cnt_q[1][0]), 64'd0);
    cyc();
    check("rst_drop_rv2", 64'(in_r_valid_o), 64'h0);

    // Escape disabled: branch 2 starves and its counter keeps counting.
    do_clear();
    mode_i = 1'b0; max_stall_i = '0; in_req_i = 12'h101; #1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("noesc_gnt%0d", c), 64'(in_gnt_o), 64'h001);
      cyc();
    end
    check("noesc_cnt", 64'(dut.cnt_q[2][0]), 64'd10);
    max_stall_i = 8'd10; #1;
    check("noesc_thr10_gnt", 64'(in_gnt_o), 64'h100);
    max_stall_i = 8'd11; #1;
    check("noesc_thr11_gnt", 64'(in_gnt_o), 64'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hci_bank_arbiter.md
HCI_BANK_ARBITER -- requirements
Module: hci_bank_arbiter

Interface
REQ-001 SHALL have parameters:
- N_IN, 3, requesting branches per bank (>=2)
- N_MEM, 4, memory banks
- AW, 32, address width
- DW, 32, data width
- BW, DW/8, byte-enable width
- IW, 8, transaction ID width
- SW, 8, starvation counter and threshold width

REQ-002 SHALL have ports (flat index for branch b, bank m is k=b*N_MEM+m):
- clk_i  in  1  sole clock
- rst_ni  in  1  reset, synchronous, active-low
- clear_i  in  1  synchronous clear, same effect as reset
- mode_i  in  1  0 = fixed priority with starvation escape, 1 = round-robin
- max_stall_i  in  SW  starvation threshold; 0 disables escape
- in_req_i  in  N_IN*N_MEM  request
- in_gnt_o  out  N_IN*N_MEM  grant
- in_add_i  in  N_IN*N_MEM*AW  address
- in_wen_i  in  N_IN*N_MEM  1 = read, 0 = write
- in_be_i  in  N_IN*N_MEM*BW  byte enables
- in_data_i  in  N_IN*N_MEM*DW  write data
- in_id_i  in  N_IN*N_MEM*IW  transaction ID
- in_r_valid_o  out  N_IN*N_MEM  response valid
- in_r_data_o  out  N_IN*N_MEM*DW  response data
- in_r_id_o  out  N_IN*N_MEM*IW  response ID
- mem_req_o  out  N_MEM  bank request
- mem_gnt_i  in  N_MEM  bank grant
- mem_add_o / mem_wen_o / mem_be_o / mem_data_o  out  N_MEM*(AW / 1 / BW / DW)  bank payload
- mem_r_data_i  in  N_MEM*DW  bank read data, valid exactly 1 cycle after handshake

Function
REQ-003 SHALL arbitrate each bank independently; there SHALL be no cross-bank state.
REQ-004 SHALL select a combinational winner w[m] among the branches with in_req_i[k]=1 (bank m); mem_req_o[m] = OR of those requests; mem payload = payload of w[m].
REQ-005 SHALL drive in_gnt_o[k] = (b==w[m]) & mem_req_o[m] & mem_gnt_i[m]; handshake = that grant; no added request-path latency.
REQ-006 Mode 0: winner = lowest-index branch with req=1 and cnt[b][m] >= max_stall_i when max_stall_i != 0; otherwise lowest-index requesting branch (branch 0 highest priority).
REQ-007 Starvation counters cnt[b][m] (SW bits): on handshake or req=0 -> 0; on req=1 without grant -> +1, saturating at 2^SW-1; counters SHALL update in both modes.
REQ-008 Mode 1: per-bank pointer ptr[m] (clog2(N_IN) bits); winner = first requesting branch cyclically from ptr[m]; on handshake ptr[m] <= (w+1) mod N_IN; without handshake ptr[m] holds.
REQ-009 A mode_i change SHALL take effect the same cycle; counters and pointers SHALL retain their values.
REQ-010 On handshake SHALL register rsel[m]<=w, rid[m]<=in_id_i of w, rpend[m]<=1; otherwise rpend[m]<=0.
REQ-011 When rpend[m]=1, in_r_valid_o[rsel*N_MEM+m] = 1 for exactly 1 cycle; in_r_id_o = rid[m]; in_r_data_o[k] = mem_r_data_i[m] for all b (broadcast, qualified by valid); response latency = 1 cycle after handshake, for reads and writes alike.
REQ-012 mem_gnt_i[m]=0 with request pending: no grant, no response next cycle, requesting counters +1, pointer holds.
REQ-013 Back-to-back handshakes on a bank SHALL give back-to-back responses; throughput = 1 per cycle per bank.

Reset
REQ-014 rst_ni=0 or clear_i=1 at a clock edge SHALL set all cnt, ptr, rsel, rid and rpend to 0; pending responses SHALL be dropped.
REQ-015 After reset, in_r_valid_o = 0; in_gnt_o and mem_req_o follow the inputs combinationally.

Verification
REQ-016 Mode 0, max_stall_i=3, branches 0 and 2 on bank 1 continuously, mem_gnt_i=1 -> grants b0,b0,b0,b2, repeating with period 4.
REQ-017 Mode 1, branches 0/1/2 on bank 0 continuously -> grants 0,1,2,0,1,2; ptr wraps from 2 to 0.
REQ-018 Branch 1 reads bank 2, addr 0x10, id 5; mem_r_data_i[2]=0xDEADBEEF next cycle -> in_r_valid_o[6]=1 with data 0xDEADBEEF and id 5; all other r_valid bits 0.
REQ-019 Mode 1, mem_gnt_i[3]=0 for 2 cycles with 2 requesters -> no grant, no r_valid, ptr unchanged, counters = 2; first grant after mem_gnt_i rises goes to the ptr-order winner.
REQ-020 rst_ni=0 in the cycle after a handshake -> no r_valid that cycle or later, cnt = 0, ptr = 0.
REQ-021 Mode 0, max_stall_i=0, branches 0 and 2 on bank 0 for 10 cycles -> branch 2 never granted; its counter reads 10.
